ppe_rr_sched_w1024: RTL and testbench
=====================================

# ppe_rr_sched_w1024

Round-robin grant scheduler built around the 1024-way programmable priority encoder `ppe_w1024`.
- Holds a pending-request bitmap and drives it, with a rotating pointer, into `ppe_w1024`.
- Converts the one-hot grant back to a 10-bit index and presents that index on a valid/ready port.
- On acceptance, retires the granted request and advances the pointer.
- Sits between request sources and the downstream consumer of grant indices.

## Interface
Parameters:
- N, 1024: number of requesters; fixed at 1024 to match `ppe_w1024`.
- W, 10: index width, log2(N).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_set  in  N  per-bit set pulses into the pending bitmap.
- ptr_load  in  1  load the pointer from ptr_load_val.
- ptr_load_val  in  W  new pointer value.
- gnt_valid  out  1  grant index valid.
- gnt_ready  in  1  consumer accepts the grant.
- gnt_idx  out  W  granted requester index.
- ptr  out  W  current priority pointer; drives P_enc of `ppe_w1024`.
- pend  out  N  pending bitmap; drives Req of `ppe_w1024`.

## Operation
- Reset values: pend=0, ptr=0, gnt_valid=0, gnt_idx=0, state=IDLE.
- Grant selection is done by the `ppe_w1024` instance:
  - grant = lowest set bit of pend at index ≥ ptr;
  - if no such bit exists, grant = lowest set bit of pend overall.
- "Any request" is the reduction-OR of pend. The `valid` output of `ppe_w1024` is left unconnected and not used.
- The one-hot Gnt is encoded to an index by the sub-module `gnt_idx_enc_w1024`.
- FSM:
  - IDLE: if |pend, register the encoded index into gnt_idx, set gnt_valid=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: gnt_idx and gnt_valid stay stable while gnt_ready=0. On gnt_valid & gnt_ready, clear pend[gnt_idx], set ptr = gnt_idx+1 mod N, set gnt_valid=0, go to IDLE.
- Pointer arithmetic is W-bit with natural wrap: gnt_idx=1023 gives ptr=0.
- pend update each cycle: pend_next = (pend & ~clr_mask) | req_set.
  - A set has priority over a clear of the same bit in the same cycle, so the bit stays pending.
- Setting a bit that is already pending has no effect; request pulses are not counted.
- ptr_load has priority over the pointer advance from an acceptance in the same cycle.
- ptr_load in HOLD changes ptr but never alters the held gnt_idx.
- Reset mid-grant: the held grant is dropped and all pending requests are lost.

## Timing
- Latency: req_set in cycle t → pend bit visible in t+1 → gnt_valid=1 in t+2 (when IDLE and nothing else is pending).
- Acceptance at edge a (valid&ready sampled high): gnt_valid=0 in a+1. If pend is still nonzero, gnt_valid=1 in a+2 with the next index.
- Peak throughput: one grant per 2 cycles.
- gnt_idx changes only on the IDLE→HOLD transition.
- The combinational path pend/ptr → `ppe_w1024` → encoder → gnt_idx register lies within one cycle. No other logic is allowed on that path.

## Structure
- Shared package `ppe_sched_pkg`: the constants N and W, and the FSM state enum (IDLE, HOLD).
- Sub-modules:
  - existing `ppe_w1024`, one instance;
  - new `gnt_idx_enc_w1024`: combinational one-hot to 10-bit encoder, an OR-tree per output bit, output 0 for all-zero input.
- Top level holds: pend register, ptr register, FSM, gnt_idx/gnt_valid registers.

## Test plan
- Reset, then idle 10 cycles → gnt_valid=0, ptr=0, pend=0 throughout.
- req_set bit 5 in cycle 0, gnt_ready=1 → gnt_valid=1, gnt_idx=5 in cycle 2; then ptr=6 and pend[5]=0.
- pend={3,700,1023}, ptr=0, gnt_ready=1 → grants issued in order 3, 700, 1023; ptr then wraps to 0.
- ptr_load 800 with pend={3,700} → gnt_idx=3 (wrap search); after acceptance ptr=4.
- gnt_ready=0 for 6 cycles in HOLD, with req_set bit 2 and ptr_load 0 during the stall → gnt_idx held stable; after release, next grant=2.
- Acceptance of idx 9 coincident with req_set bit 9 → pend[9] stays 1 and 9 is granted again. rst_n=0 during HOLD → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ppe_sched_pkg.sv
// rtl/ppe_sched_pkg.sv - shared constants and FSM state type for the round-robin grant scheduler
package ppe_sched_pkg;
   localparam int N = 1024;
   localparam int W = 10;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } sched_state_e;
endpackage

// File: rtl/gnt_idx_enc_w1024.sv
// rtl/gnt_idx_enc_w1024.sv - one-hot grant to binary index encoder, zero for an all-zero input
module gnt_idx_enc_w1024
   import ppe_sched_pkg::*;
(
   input  logic [N-1:0] i_gnt,
   output logic [W-1:0] o_idx
);
   // Each output bit is the OR of every one-hot position whose index has that bit set
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_gnt[i]) begin
            o_idx = o_idx | W'(i);
         end
      end
   end
endmodule

// File: rtl/ppe_w1024.sv
// rtl/ppe_w1024.sv - 1024-way programmable priority encoder, lowest set bit at or above P_enc, wrapping
module ppe_w1024 #(
   parameter int N = 1024,
   parameter int W = 10
) (
   input  logic [N-1:0] Req,
   input  logic [W-1:0] P_enc,
   output logic [N-1:0] Gnt,
   output logic         valid
);
   logic [N-1:0] w_upper;
   logic [N-1:0] w_upper_lo;
   logic [N-1:0] w_all_lo;

   // x & -x isolates the lowest set bit; the upper window wins whenever it has any request
   always_comb begin
      w_upper    = Req & ({N{1'b1}} << P_enc);
      w_upper_lo = w_upper & (~w_upper + N'(1));
      w_all_lo   = Req & (~Req + N'(1));
      Gnt        = (|w_upper) ? w_upper_lo : w_all_lo;
      valid      = |Req;
   end
endmodule

// File: rtl/ppe_rr_sched_w1024.sv
// rtl/ppe_rr_sched_w1024.sv - round-robin grant scheduler presenting ppe_w1024 grants on a valid/ready port
module ppe_rr_sched_w1024
   import ppe_sched_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_set,
   input  logic         ptr_load,
   input  logic [W-1:0] ptr_load_val,
   output logic         gnt_valid,
   input  logic         gnt_ready,
   output logic [W-1:0] gnt_idx,
   output logic [W-1:0] ptr,
   output logic [N-1:0] pend
);
   sched_state_e r_state;
   sched_state_e w_state_nxt;
   logic [N-1:0] r_pend;
   logic [W-1:0] r_ptr;
   logic [W-1:0] r_gnt_idx;
   logic         r_gnt_valid;
   logic [N-1:0] w_gnt_onehot;
   logic [W-1:0] w_enc_idx;
   logic [N-1:0] w_clr_mask;
   logic         w_any;
   logic         w_load_grant;
   logic         w_accept;

   ppe_w1024 #(.N(N), .W(W)) u_ppe (
      .Req   (r_pend),
      .P_enc (r_ptr),
      .Gnt   (w_gnt_onehot),
      .valid ()
   );

   gnt_idx_enc_w1024 u_enc (
      .i_gnt (w_gnt_onehot),
      .o_idx (w_enc_idx)
   );

   assign w_any = |r_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = HOLD;
         HOLD:    if (r_gnt_valid && gnt_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_load_grant = (r_state == IDLE) && w_any;
      w_accept     = (r_state == HOLD) && r_gnt_valid && gnt_ready;
      w_clr_mask   = w_accept ? (N'(1) << r_gnt_idx) : '0;
   end

   // req_set is OR-ed after the clear so a same-cycle set keeps the bit pending
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_ptr       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_clr_mask) | req_set;
         if (ptr_load) begin
            r_ptr <= ptr_load_val;
         end else if (w_accept) begin
            r_ptr <= r_gnt_idx + W'(1);
         end
         if (w_load_grant) begin
            r_gnt_idx   <= w_enc_idx;
            r_gnt_valid <= 1'b1;
         end else if (w_accept) begin
            r_gnt_valid <= 1'b0;
         end
      end
   end

   assign gnt_valid = r_gnt_valid;
   assign gnt_idx   = r_gnt_idx;
   assign ptr       = r_ptr;
   assign pend      = r_pend;
endmodule

// File: tb/tb_ppe_rr_sched_w1024.sv
// tb/tb_ppe_rr_sched_w1024.sv - directed self-checking bench for the round-robin grant scheduler
module tb_ppe_rr_sched_w1024;
   localparam int TN = 1024;
   localparam int TW = 10;

   logic          clk;
   logic          rst_n;
   logic [TN-1:0] req_set;
   logic          ptr_load;
   logic [TW-1:0] ptr_load_val;
   logic          gnt_valid;
   logic          gnt_ready;
   logic [TW-1:0] gnt_idx;
   logic [TW-1:0] ptr;
   logic [TN-1:0] pend;

   int checks;
   int failures;

   ppe_rr_sched_w1024 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_set      (req_set),
      .ptr_load     (ptr_load),
      .ptr_load_val (ptr_load_val),
      .gnt_valid    (gnt_valid),
      .gnt_ready    (gnt_ready),
      .gnt_idx      (gnt_idx),
      .ptr          (ptr),
      .pend         (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int unsigned v, input int unsigned idx,
                          input int unsigned p, input int unsigned npend);
      chk({tag, ".valid"}, gnt_valid, v);
      chk({tag, ".idx"}, gnt_idx, idx);
      chk({tag, ".ptr"}, ptr, p);
      chk({tag, ".npend"}, $countones(pend), npend);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      req_set = '0;
      ptr_load = 1'b0;
      ptr_load_val = '0;
      gnt_ready = 1'b0;
      tick();
      tick();
      chk_out("reset", 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle.valid", gnt_valid, 0);
         chk("idle.ptr", ptr, 0);
         chk("idle.npend", $countones(pend), 0);
      end

      // single request, two-cycle latency
      gnt_ready = 1'b1;
      req_set[5] = 1'b1;
      tick();
      req_set = '0;
      chk("r5.pend5", pend[5], 1);
      chk("r5.valid_t1", gnt_valid, 0);
      tick();
      chk_out("r5.grant", 1, 5, 0, 1);
      tick();
      chk_out("r5.accept", 0, 5, 6, 0);

      // three requests from ptr 0, including the wrap from 1023
      req_set[3] = 1'b1;
      req_set[700] = 1'b1;
      req_set[1023] = 1'b1;
      ptr_load = 1'b1;
      ptr_load_val = 10'd0;
      tick();
      req_set = '0;
      ptr_load = 1'b0;
      chk_out("m.load", 0, 5, 0, 3);
      tick();
      chk_out("m.g3", 1, 3, 0, 3);
      tick();
      chk_out("m.a3", 0, 3, 4, 2);
      tick();
      chk_out("m.g700", 1, 700, 4, 2);
      tick();
      chk_out("m.a700", 0, 700, 701, 1);
      tick();
      chk_out("m.g1023", 1, 1023, 701, 1);
      tick();
      chk_out("m.a1023", 0, 1023, 0, 0);

      // pointer above every request forces the wrap search
      req_set[3] = 1'b1;
      req_set[700] = 1'b1;
      ptr_load = 1'b1;
      ptr_load_val = 10'd800;
      tick();
      req_set = '0;
      ptr_load = 1'b0;
      chk("w.ptr800", ptr, 800);
      tick();
      chk_out("w.g3", 1, 3, 800, 2);
      tick();
      chk_out("w.a3", 0, 3, 4, 1);
      tick();
      chk_out("w.g700", 1, 700, 4, 1);
      tick();
      chk_out("w.a700", 0, 700, 701, 0);

      // stall in HOLD with a new request and a pointer load
      gnt_ready = 1'b0;
      req_set[10] = 1'b1;
      tick();
      req_set = '0;
      tick();
      chk_out("s.g10", 1, 10, 701, 1);
      req_set[2] = 1'b1;
      ptr_load = 1'b1;
      ptr_load_val = 10'd0;
      tick();
      req_set = '0;
      ptr_load = 1'b0;
      chk_out("s.stall0", 1, 10, 0, 2);
      for (int i = 1; i < 6; i++) begin
         tick();
         chk_out("s.stall", 1, 10, 0, 2);
      end
      gnt_ready = 1'b1;
      tick();
      chk_out("s.a10", 0, 10, 11, 1);
      tick();
      chk_out("s.g2", 1, 2, 11, 1);
      tick();
      chk_out("s.a2", 0, 2, 3, 0);

      // pointer load beats the advance on the accepting edge
      gnt_ready = 1'b0;
      req_set[20] = 1'b1;
      tick();
      req_set = '0;
      tick();
      chk_out("p.g20", 1, 20, 3, 1);
      gnt_ready = 1'b1;
      ptr_load = 1'b1;
      ptr_load_val = 10'd100;
      tick();
      ptr_load = 1'b0;
      chk_out("p.a20", 0, 20, 100, 0);

      // set and clear of the same bit on the accepting edge
      gnt_ready = 1'b0;
      req_set[9] = 1'b1;
      tick();
      req_set = '0;
      tick();
      chk_out("c.g9", 1, 9, 100, 1);
      gnt_ready = 1'b1;
      req_set[9] = 1'b1;
      tick();
      req_set = '0;
      gnt_ready = 1'b0;
      chk_out("c.a9", 0, 9, 10, 1);
      chk("c.pend9", pend[9], 1);
      tick();
      chk_out("c.g9again", 1, 9, 10, 1);

      // reset while holding a grant
      req_set[400] = 1'b1;
      tick();
      req_set = '0;
      chk_out("x.hold", 1, 9, 10, 2);
      rst_n = 1'b0;
      tick();
      chk_out("x.reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      chk_out("x.after", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
